// File: rtl/clap_pkg.sv
// Shared definitions for the clap detector: FSM state encodings and their width.
package clap_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLAP1   = 3'd1,
    ST_GAP     = 3'd2,
    ST_CLAP2   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clap_detector_if.sv
// Energy-frame stream from the windowed-energy stage into the clap detector.
interface clap_detector_if #(
  parameter int unsigned ENERGY_WIDTH = 32
);

  logic [ENERGY_WIDTH-1:0] energy_data;
  logic                    energy_valid;
  logic                    energy_ready;

  modport master (
    output energy_data,
    output energy_valid,
    input  energy_ready
  );

  modport slave (
    input  energy_data,
    input  energy_valid,
    output energy_ready
  );

endinterface

// File: rtl/clap_background.sv
// Running background-energy average (IIR) and the "hot" frame comparison against it.
module clap_background #(
  parameter int unsigned ENERGY_WIDTH = 32,
  parameter int unsigned AVG_SHIFT    = 4,
  parameter int unsigned RATIO_SHIFT  = 3,
  parameter int unsigned MIN_ENERGY   = 4096,
  parameter int unsigned BG_INIT      = 1000
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic [ENERGY_WIDTH-1:0] energy,
  input  logic                    valid,
  input  logic                    update_en,
  output logic                    hot,
  output logic [ENERGY_WIDTH-1:0] bg
);

  localparam int unsigned CmpW = ENERGY_WIDTH + RATIO_SHIFT;

  logic [ENERGY_WIDTH-1:0] bg_q, bg_d, delta;
  logic [CmpW-1:0]         energy_ext, thresh;

  // Widened compare so the scaled background can never wrap.
  assign energy_ext = {{RATIO_SHIFT{1'b0}}, energy};
  assign thresh     = {{RATIO_SHIFT{1'b0}}, bg_q} << RATIO_SHIFT;
  assign hot        = (energy > ENERGY_WIDTH'(MIN_ENERGY)) && (energy_ext > thresh);
  assign bg         = bg_q;

  // Step is a fraction of the distance to the sample, so bg stays between old bg and energy.
  always_comb begin
    bg_d  = bg_q;
    delta = '0;
    if (valid && update_en && !hot) begin
      if (energy >= bg_q) begin
        delta = (energy - bg_q) >> AVG_SHIFT;
        bg_d  = bg_q + delta;
      end else begin
        delta = (bg_q - energy) >> AVG_SHIFT;
        bg_d  = bg_q - delta;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      bg_q <= ENERGY_WIDTH'(BG_INIT);
    end else begin
      bg_q <= bg_d;
    end
  end

endmodule

// File: rtl/clap_detector.sv
// Clap / gap / clap recogniser: toggles the light on a double clap, then locks out.
// All timing is counted in accepted energy frames.
module clap_detector
  import clap_pkg::*;
#(
  parameter int unsigned ENERGY_WIDTH = 32,
  parameter int unsigned AVG_SHIFT    = 4,
  parameter int unsigned RATIO_SHIFT  = 3,
  parameter int unsigned MIN_ENERGY   = 4096,
  parameter int unsigned BG_INIT      = 1000,
  parameter int unsigned MAX_CLAP_LEN = 4,
  parameter int unsigned GAP_MIN      = 2,
  parameter int unsigned GAP_MAX      = 40,
  parameter int unsigned LOCKOUT_LEN  = 50
) (
  input  logic               clock,
  input  logic               nreset,
  clap_detector_if.slave     energy_if,
  output logic               light,
  output logic               clap_pulse,
  output logic               toggle_pulse,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int unsigned CntMax = max_u(GAP_MAX, LOCKOUT_LEN);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [CntW:0]           cnt_plus;
  logic                    light_q, light_d;
  logic                    clap_q, clap_d;
  logic                    toggle_q, toggle_d;
  logic                    hot;
  logic                    accept;
  logic [ENERGY_WIDTH-1:0] bg;
  logic                    unused_bg;

  assign energy_if.energy_ready = 1'b1;
  assign accept                 = energy_if.energy_valid;

  clap_background #(
    .ENERGY_WIDTH (ENERGY_WIDTH),
    .AVG_SHIFT    (AVG_SHIFT),
    .RATIO_SHIFT  (RATIO_SHIFT),
    .MIN_ENERGY   (MIN_ENERGY),
    .BG_INIT      (BG_INIT)
  ) u_bg (
    .clock     (clock),
    .nreset    (nreset),
    .energy    (energy_if.energy_data),
    .valid     (accept),
    .update_en (state_q == ST_IDLE),
    .hot       (hot),
    .bg        (bg)
  );

  // Background level is kept visible at this level for debug probing only.
  assign unused_bg = ^bg;

  assign cnt_plus = {1'b0, cnt_q} + 1'b1;
  assign cnt_inc  = (cnt_q == CntW'(CntMax)) ? cnt_q : cnt_plus[CntW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    light_d  = light_q;
    clap_d   = 1'b0;
    toggle_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hot) begin
            state_d = ST_CLAP1;
            cnt_d   = CntW'(1);
          end
        end
        ST_CLAP1, ST_CLAP2: begin
          if (hot) begin
            // A clap that lasts too long is treated as noise.
            if (cnt_plus == (CntW+1)'(MAX_CLAP_LEN)) begin
              state_d = ST_LOCKOUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (state_q == ST_CLAP1) begin
            state_d = ST_GAP;
            cnt_d   = CntW'(1);
            clap_d  = 1'b1;
          end else begin
            light_d  = ~light_q;
            clap_d   = 1'b1;
            toggle_d = 1'b1;
            state_d  = ST_LOCKOUT;
            cnt_d    = '0;
          end
        end
        ST_GAP: begin
          if (!hot) begin
            if (cnt_plus == (CntW+1)'(GAP_MAX)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (cnt_q >= CntW'(GAP_MIN)) begin
            state_d = ST_CLAP2;
            cnt_d   = CntW'(1);
          end else begin
            state_d = ST_LOCKOUT;
            cnt_d   = '0;
          end
        end
        ST_LOCKOUT: begin
          // Once the hold-off has elapsed, leave only on a quiet frame.
          if (cnt_q >= CntW'(LOCKOUT_LEN - 1)) begin
            if (!hot) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      light_q  <= 1'b0;
      clap_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      light_q  <= light_d;
      clap_q   <= clap_d;
      toggle_q <= toggle_d;
    end
  end

  assign light        = light_q;
  assign clap_pulse   = clap_q;
  assign toggle_pulse = toggle_q;
  assign state_dbg    = state_q;

endmodule
